// File: rtl/fifo_sram_prefetch.sv
// First-word-fall-through FIFO built on a simple-dual-port SRAM model with
// configurable read latency. A small register prefetch buffer of
// READ_LATENCY+1 entries sits in front of the SRAM. It keeps data_o valid
// whenever empty_o is low and allows one pop every cycle without bubbles.
module fifo_sram_prefetch #(
    parameter int WIDTH           = 10,
    parameter int DEPTH           = 10,
    parameter int READ_LATENCY    = 1,
    parameter int ALMOST_FULL_THR = DEPTH - 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en_i,
    input  logic                       rd_en_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almost_full_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int AW  = $clog2(DEPTH);
    localparam int PF  = READ_LATENCY + 1;
    localparam int PW  = $clog2(PF);
    localparam int PCW = $clog2(PF + 1);

    // SRAM array and its read-data pipeline
    logic [WIDTH-1:0]        mem [DEPTH];
    logic [WIDTH-1:0]        pipe_q [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_q;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    // Words committed to the SRAM and not yet issued for reading
    logic [CW-1:0]           sram_cnt;
    logic [CW-1:0]           count_q;

    // Prefetch register FIFO
    logic [WIDTH-1:0]        pf_mem [PF];
    logic [PW-1:0]           pf_head;
    logic [PW-1:0]           pf_tail;
    logic [PCW-1:0]          pf_cnt;

    logic                    wr_acc;
    logic                    rd_acc;
    logic                    issue;
    logic                    land;
    int                      occ;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PW-1:0] pf_inc(input logic [PW-1:0] p);
        return (p == PW'(PF - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o       = (pf_cnt == '0);
    assign data_o        = pf_mem[pf_head];
    assign count_o       = count_q;
    assign full_o        = (count_q == CW'(DEPTH));
    assign almost_full_o = (count_q >= CW'(ALMOST_FULL_THR));
    assign land          = vld_q[READ_LATENCY-1];

    // Accept decisions and SRAM read issue; only words committed at an earlier edge are eligible
    always_comb begin
        // NOTE: every output of a combinational block is assigned before any branch, so no latch can be inferred.
        rd_acc = 1'b0;
        wr_acc = 1'b0;
        issue  = 1'b0;
        occ    = 0;
        rd_acc = rd_en_i && !empty_o;
        wr_acc = wr_en_i && (!full_o || rd_acc);
        occ    = int'(pf_cnt) + $countones(vld_q) - int'(rd_acc);
        issue  = (sram_cnt != '0) && (occ < PF);
    end

    // Storage datapath: SRAM write, SRAM read pipeline and prefetch slots
    always_ff @(posedge clk_i) begin
        // NOTE: storage arrays carry no reset; the valid bits and pointers alone decide what is live.
        if (wr_acc) mem[wr_ptr] <= data_i;
        if (issue) pipe_q[0] <= mem[rd_ptr];
        for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        if (land) pf_mem[pf_tail] <= pipe_q[READ_LATENCY-1];
    end

    // Control state: pointers, occupancies, in-flight valids and sticky flags
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            sram_cnt    <= '0;
            count_q     <= '0;
            vld_q       <= '0;
            pf_head     <= '0;
            pf_tail     <= '0;
            pf_cnt      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (issue)  rd_ptr <= ptr_inc(rd_ptr);
            sram_cnt <= sram_cnt + CW'(wr_acc) - CW'(issue);

            vld_q[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];

            if (land)   pf_tail <= pf_inc(pf_tail);
            if (rd_acc) pf_head <= pf_inc(pf_head);
            pf_cnt <= pf_cnt + PCW'(land) - PCW'(rd_acc);

            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (wr_en_i && !wr_acc) overflow_o  <= 1'b1;
            if (rd_en_i && !rd_acc) underflow_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_sram_prefetch.sv
// Directed self-checking bench for fifo_sram_prefetch.
// DUT a: DEPTH=10, READ_LATENCY=1. DUT b: DEPTH=10, READ_LATENCY=3.
module tb_fifo_sram_prefetch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       wr_a = 1'b0, rd_a = 1'b0;
    logic [9:0] din_a = '0, dout_a;
    logic       empty_a, full_a, af_a, ov_a, un_a;
    logic [3:0] count_a;

    logic       wr_b = 1'b0, rd_b = 1'b0;
    logic [9:0] din_b = '0, dout_b;
    logic       empty_b, full_b, af_b, ov_b, un_b;
    logic [3:0] count_b;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_sram_prefetch #(.WIDTH(10), .DEPTH(10), .READ_LATENCY(1), .ALMOST_FULL_THR(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_a), .rd_en_i(rd_a), .data_i(din_a),
        .data_o(dout_a), .empty_o(empty_a), .full_o(full_a), .almost_full_o(af_a),
        .count_o(count_a), .overflow_o(ov_a), .underflow_o(un_a)
    );

    fifo_sram_prefetch #(.WIDTH(10), .DEPTH(10), .READ_LATENCY(3), .ALMOST_FULL_THR(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_b), .rd_en_i(rd_b), .data_i(din_b),
        .data_o(dout_b), .empty_o(empty_b), .full_o(full_b), .almost_full_o(af_b),
        .count_o(count_b), .overflow_o(ov_b), .underflow_o(un_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_b(input string tag);
        check({tag, "_empty"}, empty_b, 1);
        check({tag, "_full"},  full_b,  0);
        check({tag, "_af"},    af_b,    0);
        check({tag, "_count"}, count_b, 0);
        check({tag, "_ov"},    ov_b,    0);
        check({tag, "_un"},    un_b,    0);
    endtask

    initial begin
        int wcnt;
        int rcnt;

        // Reset state of both instances
        repeat (2) step();
        check("rst_a_empty", empty_a, 1);
        check("rst_a_full",  full_a,  0);
        check("rst_a_af",    af_a,    0);
        check("rst_a_count", count_a, 0);
        check("rst_a_ov",    ov_a,    0);
        check("rst_a_un",    un_a,    0);
        check_reset_b("rst_b");
        rst = 1'b0;
        step();

        // Fill 1..10, no reads: head appears 3 edges after first write
        wr_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            din_a = 10'(i);
            step();
            check("fill_count", count_a, i);
            check("fill_full",  full_a,  32'(i == 10));
            check("fill_af",    af_a,    32'(i >= 8));
            check("fill_empty", empty_a, 32'(i < 3));
            if (i >= 3) check("fill_head", dout_a, 1);
        end
        wr_a = 1'b0;

        // Pop 10 back-to-back
        rd_a = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            check("pop_data",  dout_a,  i);
            check("pop_empty", empty_a, 0);
            step();
            check("pop_count", count_a, 10 - i);
        end
        rd_a = 1'b0;
        check("drain_empty", empty_a, 1);
        check("drain_full",  full_a,  0);
        check("drain_ov",    ov_a,    0);
        check("drain_un",    un_a,    0);

        // Refill 11..20 to full
        wr_a = 1'b1;
        for (int i = 11; i <= 20; i++) begin
            din_a = 10'(i);
            step();
        end
        check("refill_full", full_a, 1);

        // Full with simultaneous write and read for 5 cycles
        rd_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din_a = 10'(21 + i);
            check("fullrw_data", dout_a, 11 + i);
            step();
            check("fullrw_count", count_a, 10);
            check("fullrw_ov",    ov_a,    0);
        end
        rd_a = 1'b0;

        // Write at full without read
        din_a = 10'd99;
        step();
        wr_a = 1'b0;
        check("ovf_flag",  ov_a,    1);
        check("ovf_count", count_a, 10);
        check("ovf_head",  dout_a,  16);

        // Drain 16..25; the rejected 99 must not appear
        rd_a = 1'b1;
        for (int i = 16; i <= 25; i++) begin
            check("pop2_data", dout_a, i);
            step();
        end
        rd_a = 1'b0;
        check("pop2_empty", empty_a, 1);
        check("pop2_count", count_a, 0);

        // Empty with simultaneous write and read: write taken, read rejected
        wr_a = 1'b1; rd_a = 1'b1; din_a = 10'd7;
        step();
        wr_a = 1'b0; rd_a = 1'b0;
        check("unf_flag",  un_a,    1);
        check("unf_count", count_a, 1);
        step();
        check("unf_empty_k1", empty_a, 1);
        step();
        check("unf_empty_k2", empty_a, 0);
        check("unf_data",     dout_a,  7);
        rd_a = 1'b1;
        step();
        rd_a = 1'b0;
        check("unf_drained", empty_a, 1);
        repeat (3) step();
        check("sticky_ov", ov_a, 1);
        check("sticky_un", un_a, 1);

        // READ_LATENCY=3 streaming: prime, then continuous write+read
        wcnt = 0;
        rcnt = 0;
        wr_b = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            din_b = 10'(wcnt);
            step();
            wcnt++;
            check("b_prime_empty", empty_b, 32'(i < 5));
        end
        check("b_prime_data", dout_b, 0);
        rd_b = 1'b1;
        for (int i = 0; i < 60; i++) begin
            din_b = 10'(wcnt);
            check("b_stream_data",  dout_b,  rcnt);
            check("b_stream_empty", empty_b, 0);
            step();
            wcnt++;
            rcnt++;
            check("b_stream_count", count_b, 5);
        end

        // Reset mid-stream
        rst = 1'b1;
        #1;
        check_reset_b("b_midrst");
        rst = 1'b0;
        wr_b = 1'b0; rd_b = 1'b0;
        step();

        // Two words written, then reset with both reads in flight
        wr_b = 1'b1; din_b = 10'h155;
        step();
        din_b = 10'h002;
        step();
        wr_b = 1'b0;
        step();
        check("b_inflight_count", count_b, 2);
        check("b_inflight_empty", empty_b, 1);
        rst = 1'b1;
        #1;
        check_reset_b("b_flightrst");
        rst = 1'b0;

        // After release only the new word must come out
        wr_b = 1'b1; din_b = 10'h0AA;
        step();
        wr_b = 1'b0;
        check("b_aa_count", count_b, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("b_aa_wait_empty", empty_b, 1);
        end
        step();
        check("b_aa_empty", empty_b, 0);
        check("b_aa_data",  dout_b,  10'h0AA);
        rd_b = 1'b1;
        step();
        rd_b = 1'b0;
        check("b_aa_popped", empty_b, 1);
        repeat (4) step();
        check("b_no_stale_empty", empty_b, 1);
        check("b_no_stale_count", count_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
